// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: shared FP word layout and shadow-pipeline tag entry for the accelerator schedulers
package fp_acc_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int TAG_MAX_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past ptr, one-hot grant plus encoded index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      gnt = req[j] ? N'(1) << j : gnt;
      idx = req[j] ? IW'(j) : idx;
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin scheduler sharing one pipelined FP adder among N_REQ requesters
module fp_add_arbiter
  import fp_acc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADD_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [FP_W-1:0]       add_a,
  output logic [FP_W-1:0]       add_b,
  output logic                  add_in_valid,
  input  logic [FP_W-1:0]       add_out,
  input  logic                  add_out_valid,
  output logic [FP_W-1:0]       res_data,
  output logic [N_REQ-1:0]      res_valid,
  output logic                  busy,
  output logic                  err
);
  localparam int TAG_W = $clog2(N_REQ);
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [N_REQ-1:0] gnt, res_valid_q, res_valid_d;
  logic [FP_W-1:0] add_a_q, add_a_d, add_b_q, add_b_d, res_data_q, res_data_d;
  tag_entry_t [ADD_LAT:0] shd_q, shd_d;
  logic err_q, err_d, xfer, ret;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  assign req_ready = rst ? '0 : gnt;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign add_in_valid = shd_q[0].valid;
  assign res_data = res_data_q;
  assign res_valid = res_valid_q;
  assign err = err_q;
  always_comb begin
    xfer = |req_ready;
    ret = shd_q[ADD_LAT].valid & add_out_valid;
    rr_ptr_d = xfer ? gnt_idx : rr_ptr_q;
    add_a_d = xfer ? req_a[gnt_idx*FP_W +: FP_W] : add_a_q;
    add_b_d = xfer ? req_b[gnt_idx*FP_W +: FP_W] : add_b_q;
    shd_d = {shd_q[ADD_LAT-1:0], tag_entry_t'{valid: xfer, tag: TAG_MAX_W'(gnt_idx)}};
    res_valid_d = ret ? N_REQ'(1) << shd_q[ADD_LAT].tag : '0;
    res_data_d = ret ? add_out : res_data_q;
    err_d = err_q | (add_out_valid ^ shd_q[ADD_LAT].valid);
  end
  always_comb begin
    busy = |res_valid_q;
    for (int i = 0; i <= ADD_LAT; i++) busy = busy | shd_q[i].valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= TAG_W'(N_REQ - 1);
      add_a_q <= '0;
      add_b_q <= '0;
      shd_q <= '0;
      res_valid_q <= '0;
      res_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      shd_q <= shd_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: random and directed checks of the shared-adder scheduler against a scoreboard model
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inject = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready, res_valid;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [31:0] add_a, add_b, add_out, res_data;
  logic add_in_valid, add_out_valid, busy, err;
  logic [31:0] md [L];
  logic [L-1:0] mv;
  typedef struct {
    int iss;
    int due;
    int tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } op_t;
  op_t q[$];
  op_t o;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int ptr = N - 1;
  int g;
  logic err_exp = 1'b0;
  logic due_now, in_now;

  fp_add_arbiter #(.N_REQ(N), .ADD_LAT(L)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .add_a(add_a),
    .add_b(add_b),
    .add_in_valid(add_in_valid),
    .add_out(add_out),
    .add_out_valid(add_out_valid),
    .res_data(res_data),
    .res_valid(res_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    real r;
    r = real'($urandom_range(0, 4000)) / 4.0;
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2f(r);
  endfunction

  function automatic int exp_grant(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = rnd_fp();
      req_b[i*32 +: 32] = rnd_fp();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= '0;
    end else begin
      mv <= {mv[L-2:0], add_in_valid};
      md[0] <= fadd(add_a, add_b);
      for (int k = 1; k < L; k++) md[k] <= md[k-1];
    end
  end
  assign add_out = md[L-1];
  assign add_out_valid = mv[L-1] | inject;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      q.delete();
      ptr = N - 1;
      err_exp = 1'b0;
    end else begin
      due_now = q.size() != 0 && q[0].due == cyc;
      chk("res_valid", 32'(res_valid), due_now ? 32'd1 << q[0].tag : 32'd0);
      if (due_now) chk("res_data", res_data, q[0].sum);
      chk("busy", 32'(busy), 32'(q.size() != 0 && q[0].iss <= cyc));
      in_now = q.size() != 0 && q[$].iss == cyc;
      chk("add_in_valid", 32'(add_in_valid), 32'(in_now));
      if (in_now) begin
        chk("add_a", add_a, q[$].a);
        chk("add_b", add_b, q[$].b);
      end
      if (due_now) void'(q.pop_front());
      chk("err", 32'(err), 32'(err_exp));
      err_exp = err_exp | inject;
      g = exp_grant(req_valid, ptr);
      chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
      if (g >= 0) begin
        o.iss = cyc + 1;
        o.due = cyc + L + 2;
        o.tag = g;
        o.a = req_a[g*32 +: 32];
        o.b = req_b[g*32 +: 32];
        o.sum = fadd(o.a, o.b);
        q.push_back(o);
        ptr = g;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    #1;
    rst = 1'b1;
    req_valid = '1;
    rand_ops();
    repeat (3) begin
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'd1 << (i % 4));
      tick();
      rand_ops();
    end
    req_valid = '0;
    drain();

    tick();
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3FC00000;
    req_b[64 +: 32] = 32'h40100000;
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (res_valid != '0) begin
        chk("single_latency", k, 32'd5);
        chk("single_res_valid", 32'(res_valid), 32'h4);
        chk("single_res_data", res_data, 32'h40700000);
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("single_timeout", 32'(found), 32'd1);
    @(negedge clk);
    chk("single_busy_low", 32'(busy), 32'd0);

    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("wrap_grant0", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("wrap_grant1", 32'(req_ready), 32'h8);
    tick();
    @(negedge clk);
    chk("wrap_grant2", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    drain();

    tick();
    req_valid = '1;
    rand_ops();
    repeat (3) begin
      @(negedge clk);
      tick();
      rand_ops();
    end
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_res", 32'(res_valid), 32'd0);
    end
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();
    req_valid = '1;
    @(negedge clk);
    chk("midrst_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    drain();

    repeat (300) begin
      tick();
      req_valid = N'($urandom);
      rand_ops();
    end
    tick();
    req_valid = '0;
    drain();

    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("err_hold", 32'(err), 32'd1);
      chk("err_no_res", 32'(res_valid), 32'd0);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("err_clear", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
